// File: rtl/reg_file_bus_reader_if.sv
// Bus-side bundle for the register-file read/write port. The control
// unit / datapath drives the master side; the register file is the slave.
interface reg_file_bus_reader_if;
  logic [31:0] ir;
  logic        gra;
  logic        grb;
  logic        grc;
  logic        rin;
  logic        rout;
  logic        baout;
  logic [31:0] bus_in;
  logic [31:0] bus_out;
  logic        rd_valid;
  logic        sel_err;
  logic [31:0] c_sext;

  modport master (
    output ir, gra, grb, grc, rin, rout, baout, bus_in,
    input  bus_out, rd_valid, sel_err, c_sext
  );

  modport slave (
    input  ir, gra, grb, grc, rin, rout, baout, bus_in,
    output bus_out, rd_valid, sel_err, c_sext
  );
endinterface

// File: rtl/reg_file_bus_reader.sv
// Register file R0..R(NUM_REGS-1) with IR-field select/encode, bus write,
// registered bus read (one-cycle latency plus valid strobe), base-address
// read where R0 reads as zero, a registered multi-select error strobe and a
// registered sign extension of the IR constant field.
module reg_file_bus_reader #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] INIT_VAL = 32'h00000000
) (
  input logic                  clk,
  input logic                  clr,
  reg_file_bus_reader_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;
  localparam int C_W    = 19;

  // Sign-extend the 19-bit IR constant field to the datapath width.
  function automatic logic signed [DATA_W-1:0] sext_c(input logic [C_W-1:0] f);
    logic signed [C_W-1:0] s;
    s = f;
    return DATA_W'(s);
  endfunction

  logic [DATA_W-1:0]        regs [NUM_REGS];

  logic [IDX_W-1:0]         sel_p0;
  logic                     sel_ok_p0;
  logic                     multi_gr_p0;
  logic                     any_op_p0;
  logic                     rd_req_p0;
  logic                     wr_req_p0;
  logic [DATA_W-1:0]        rd_val_p0;

  logic [DATA_W-1:0]        rdata_p1;
  logic                     vld_p1;
  logic                     err_p1;
  logic signed [DATA_W-1:0] csext_p1;

  // Stage p0: decode the select field, the error condition and the read value.
  always_comb begin
    sel_p0      = bus.ir[18:15];
    if (bus.gra)
      sel_p0 = bus.ir[26:23];
    else if (bus.grb)
      sel_p0 = bus.ir[22:19];
    sel_ok_p0   = (bus.gra | bus.grb | bus.grc) && (int'(sel_p0) < NUM_REGS);
    multi_gr_p0 = (bus.gra & bus.grb) | (bus.gra & bus.grc) | (bus.grb & bus.grc);
    any_op_p0   = bus.rin | bus.rout | bus.baout;
    rd_req_p0   = sel_ok_p0 & (bus.rout | bus.baout);
    wr_req_p0   = sel_ok_p0 & bus.rin;
    // Base-address reads of R0 return zero; reads sample pre-write contents.
    rd_val_p0   = '0;
    if (sel_ok_p0 && !(bus.baout && sel_p0 == '0))
      rd_val_p0 = regs[sel_p0];
  end

  // Register array: reset to INIT_VAL, write bus_in into the selected register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= INIT_VAL;
    end else if (wr_req_p0) begin
      regs[sel_p0] <= bus.bus_in;
    end
  end

  // Stage p1: registered read data, valid and error strobes, sign extension.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      csext_p1 <= '0;
    end else begin
      vld_p1   <= rd_req_p0;
      err_p1   <= multi_gr_p0 & any_op_p0;
      csext_p1 <= sext_c(bus.ir[C_W-1:0]);
      if (rd_req_p0)
        rdata_p1 <= rd_val_p0;
    end
  end

  assign bus.bus_out  = rdata_p1;
  assign bus.rd_valid = vld_p1;
  assign bus.sel_err  = err_p1;
  assign bus.c_sext   = csext_p1;

endmodule

// File: tb/tb_reg_file_bus_reader.sv
// Self-checking bench for reg_file_bus_reader: directed scenarios with
// literal expectations plus randomized traffic, all compared every cycle
// against a behavioural model of the register file.
module tb_reg_file_bus_reader;

  logic clk;
  logic clr;
  reg_file_bus_reader_if bus ();

  reg_file_bus_reader #(
    .NUM_REGS (16),
    .INIT_VAL (32'h00000000)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model: an array of registers plus expected output values.
  logic [31:0] m_regs [16];
  logic [31:0] e_bus   = '0;
  logic        e_vld   = 1'b0;
  logic        e_err   = 1'b0;
  logic [31:0] e_csext = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every edge, from the rules of the register file.
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      e_bus = '0; e_vld = 1'b0; e_err = 1'b0; e_csext = '0;
    end else begin
      automatic int   ngr = int'(bus.gra) + int'(bus.grb) + int'(bus.grc);
      automatic bit   any = (ngr > 0);
      automatic int   s   = bus.gra ? int'(bus.ir[26:23]) :
                            bus.grb ? int'(bus.ir[22:19]) : int'(bus.ir[18:15]);
      automatic logic signed [18:0] cf = bus.ir[18:0];
      e_err   = (ngr >= 2) && (bus.rin || bus.rout || bus.baout);
      e_csext = 32'(cf);
      e_vld   = any && (bus.rout || bus.baout);
      if (e_vld) e_bus = (bus.baout && s == 0) ? 32'h0 : m_regs[s];
      if (any && bus.rin) m_regs[s] = bus.bus_in;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_out",  bus.bus_out,         e_bus);
      check("rd_valid", 32'(bus.rd_valid),   32'(e_vld));
      check("sel_err",  32'(bus.sel_err),    32'(e_err));
      check("c_sext",   bus.c_sext,          e_csext);
    end
  end

  function automatic logic [31:0] mk_ir(input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [3:0] rc);
    logic [31:0] v;
    v = 32'h0;
    v[26:23] = ra;
    v[22:19] = rb;
    v[18:15] = rc;
    return v;
  endfunction

  task automatic drive(input logic [31:0] ir, input logic [2:0] gr, input logic rin,
                       input logic rout, input logic baout, input logic [31:0] din);
    bus.ir     = ir;
    bus.gra    = gr[2];
    bus.grb    = gr[1];
    bus.grc    = gr[0];
    bus.rin    = rin;
    bus.rout   = rout;
    bus.baout  = baout;
    bus.bus_in = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
  endtask

  initial begin
    clr = 1'b0;
    drive(32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) step();
    check("reset bus_out",  bus.bus_out, 32'h0);
    check("reset rd_valid", 32'(bus.rd_valid), 32'h0);
    check("reset sel_err",  32'(bus.sel_err), 32'h0);
    check("reset c_sext",   bus.c_sext, 32'h0);
    clr = 1'b1;
    chk_en = 1'b1;
    idle();

    // Write/read basic on ra=5.
    drive(mk_ir(4'd5, 4'd0, 4'd0), 3'b100, 1'b1, 1'b0, 1'b0, 32'h12345678); step();
    drive(mk_ir(4'd5, 4'd0, 4'd0), 3'b100, 1'b0, 1'b1, 1'b0, 32'h0); step();
    check("wr/rd data",  bus.bus_out, 32'h12345678);
    check("wr/rd valid", 32'(bus.rd_valid), 32'h1);
    idle();
    check("wr/rd valid one cycle", 32'(bus.rd_valid), 32'h0);
    check("wr/rd hold", bus.bus_out, 32'h12345678);

    // Base address on R0 and R7 through the rb field.
    drive(mk_ir(4'd9, 4'd0, 4'd0), 3'b010, 1'b1, 1'b0, 1'b0, 32'hAAAA5555); step();
    drive(mk_ir(4'd9, 4'd7, 4'd0), 3'b010, 1'b1, 1'b0, 1'b0, 32'h00000010); step();
    drive(mk_ir(4'd9, 4'd0, 4'd0), 3'b010, 1'b0, 1'b0, 1'b1, 32'h0); step();
    check("baout R0", bus.bus_out, 32'h0);
    check("baout R0 valid", 32'(bus.rd_valid), 32'h1);
    drive(mk_ir(4'd9, 4'd0, 4'd0), 3'b010, 1'b0, 1'b1, 1'b0, 32'h0); step();
    check("rout R0", bus.bus_out, 32'hAAAA5555);
    drive(mk_ir(4'd9, 4'd0, 4'd0), 3'b010, 1'b0, 1'b1, 1'b1, 32'h0); step();
    check("rout+baout R0", bus.bus_out, 32'h0);
    drive(mk_ir(4'd9, 4'd7, 4'd0), 3'b010, 1'b0, 1'b0, 1'b1, 32'h0); step();
    check("baout R7", bus.bus_out, 32'h00000010);
    idle();

    // Read-during-write on R2: pre-write value, then new value.
    drive(mk_ir(4'd2, 4'd0, 4'd0), 3'b100, 1'b1, 1'b0, 1'b0, 32'h1); step();
    drive(mk_ir(4'd2, 4'd0, 4'd0), 3'b100, 1'b1, 1'b1, 1'b0, 32'h2); step();
    check("rdw old value", bus.bus_out, 32'h1);
    drive(mk_ir(4'd2, 4'd0, 4'd0), 3'b100, 1'b0, 1'b1, 1'b0, 32'h0); step();
    check("rdw new value", bus.bus_out, 32'h2);
    check("rdw back-to-back valid", 32'(bus.rd_valid), 32'h1);
    idle();

    // Select priority and error strobe.
    drive(mk_ir(4'd1, 4'd0, 4'd0), 3'b100, 1'b1, 1'b0, 1'b0, 32'h11); step();
    drive(mk_ir(4'd2, 4'd0, 4'd0), 3'b100, 1'b1, 1'b0, 1'b0, 32'h22); step();
    drive(mk_ir(4'd1, 4'd2, 4'd0), 3'b110, 1'b0, 1'b1, 1'b0, 32'h0); step();
    check("priority data", bus.bus_out, 32'h11);
    check("sel_err set", 32'(bus.sel_err), 32'h1);
    drive(mk_ir(4'd1, 4'd2, 4'd1), 3'b000, 1'b1, 1'b0, 1'b0, 32'hFF); step();
    check("sel_err one cycle", 32'(bus.sel_err), 32'h0);
    drive(mk_ir(4'd1, 4'd0, 4'd0), 3'b100, 1'b0, 1'b1, 1'b0, 32'h0); step();
    check("no-select write ignored", bus.bus_out, 32'h11);
    drive(mk_ir(4'd1, 4'd0, 4'd0), 3'b000, 1'b0, 1'b1, 1'b1, 32'h0); step();
    check("no-select read ignored", 32'(bus.rd_valid), 32'h0);

    // Sign extension.
    drive(32'h00040000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0); step();
    check("sext neg", bus.c_sext, 32'hFFFC0000);
    drive(32'hFFF3FFFF, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0); step();
    check("sext pos", bus.c_sext, 32'h0003FFFF);
    idle();

    // Reset mid-read.
    drive(mk_ir(4'd0, 4'd0, 4'd3), 3'b001, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF); step();
    drive(mk_ir(4'd0, 4'd0, 4'd3), 3'b001, 1'b0, 1'b1, 1'b0, 32'h0);
    #2 clr = 1'b0;
    #1;
    check("mid-read reset bus_out", bus.bus_out, 32'h0);
    check("mid-read reset rd_valid", 32'(bus.rd_valid), 32'h0);
    drive(32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    clr = 1'b1;
    drive(mk_ir(4'd0, 4'd0, 4'd3), 3'b001, 1'b0, 1'b1, 1'b0, 32'h0);
    #3;
    check("post-release rd_valid", 32'(bus.rd_valid), 32'h0);
    step();
    check("R3 after reset", bus.bus_out, 32'h0);
    check("R3 after reset valid", 32'(bus.rd_valid), 32'h1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      automatic logic [31:0] ir  = $urandom;
      automatic logic [2:0]  gr  = 3'($urandom_range(0, 7));
      automatic logic [2:0]  ops = 3'($urandom_range(0, 7));
      automatic logic [31:0] din = $urandom;
      drive(ir, gr, ops[0], ops[1], ops[2], din);
      step();
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_bus_reader.md
Name: reg_file_bus_reader

Overview:
- Register-file read/write port for the datapath: holds R0..R15, takes writes from the bus and drives the selected register back onto the bus.
- Decodes register selection from IR fields (select/encode) and asserts Rin/Rout/BAout as the control unit sequences them.
- Implements base-address semantics: R0 reads as zero when BAout is asserted.
- Read data is registered: one-cycle latency with a valid strobe.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; the index is IR 4-bit field, with fixed width 4.
- INIT_VAL, 32'h00000000, value loaded into every register on reset.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- ir  in  32  instruction register; ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- gra  in  1  select ra field.
- grb  in  1  select rb field.
- grc  in  1  select rc field.
- rin  in  1  write bus_in into the selected register.
- rout  in  1  read the selected register onto bus_out.
- baout  in  1  base-address read; R0 returns zero.
- bus_in  in  32  BusMuxOut write data.
- bus_out  out  32  registered read data.
- rd_valid  out  1  one-cycle strobe: bus_out was updated this cycle.
- sel_err  out  1  one-cycle strobe: more than one of gra/grb/grc was asserted with rin/rout/baout.
- c_sext  out  32  registered sign-extension of ir[18:0].

Behaviour:
- Reset (clr low, asynchronous, any time):
  - All registers are loaded with INIT_VAL.
  - bus_out=0, rd_valid=0, sel_err=0, c_sext=0.
  - An in-flight read is discarded. rd_valid stays 0 in the first cycle after release.
- Select/encode (combinational):
  - Selected index sel = ra if gra; else rb if grb; else rc if grc.
  - Priority is gra>grb>grc.
  - If none of gra/grb/grc is asserted, no register is selected: rin, rout and baout are all ignored.
- sel_err: registered.
  - It is 1 in cycle N+1 iff in cycle N two or more of gra/grb/grc were high and any of rin/rout/baout was high.
  - The operation still proceeds using the priority select.
- Write:
  - On a rising edge with rin=1 and a valid select, reg[sel] <= bus_in.
  - R0 is writable; BAout does not affect writes.
- Read:
  - If rout or baout is 1 at edge N with a valid select, then at N+1 rd_valid=1 and bus_out = value.
  - value = 0 if baout=1 and sel=0; otherwise reg[sel].
  - rout and baout together behave as baout.
  - baout with sel!=0 returns reg[sel] unmodified.
- Read-during-write, same register, same edge: the read returns the pre-write value (no bypass). The new value is visible to reads issued from the next edge onward.
- Back-to-back reads on consecutive cycles: rd_valid stays high every cycle. bus_out updates every cycle.
- When no read is issued: rd_valid=0 and bus_out holds its last value.
- c_sext <= {{13{ir[18]}}, ir[18:0]} every edge, regardless of controls.
- No internal state other than the registers and the output flops. No stalls; throughput is one read plus one write per cycle.

Test Plan:
- Reset mid-read:
  - Stimulus: write R3=32'hDEADBEEF; issue rout on R3; pull clr low before the next edge.
  - Required: bus_out=0, rd_valid=0; R3 reads back INIT_VAL after release.
- Write/read basic:
  - Stimulus: ir ra=5; gra+rin with bus_in=32'h12345678; next cycle gra+rout.
  - Required: one cycle later bus_out=32'h12345678 and rd_valid=1 for exactly one cycle.
- Base address:
  - Stimulus: write R0=32'hAAAA5555 via grb (rb=0).
  - grb+baout -> bus_out=0.
  - grb+rout -> bus_out=32'hAAAA5555.
  - Same sequence with rb=7 holding 32'h00000010 -> baout returns 32'h00000010.
- Read-during-write:
  - Stimulus: R2=32'h1; same cycle rin+rout on R2 with bus_in=32'h2.
  - Required: bus_out=32'h1; the next read returns 32'h2.
- Select priority/error:
  - Stimulus: ra=1 (R1=32'h11), rb=2 (R2=32'h22); gra+grb+rout.
  - Required: bus_out=32'h11, sel_err=1 for one cycle.
  - With no gr* asserted, rin with bus_in=32'hFF changes nothing.
- Sign extension:
  - ir[18:0]=19'h40000 -> c_sext=32'hFFFC0000 next cycle.
  - ir[18:0]=19'h3FFFF -> c_sext=32'h0003FFFF.
